// File: rtl/rx_unit.sv
// Oversampling UART receiver: 2-FF input synchronizer, start-bit qualification,
// 8N1 deserialisation, and rs/fe/oe status flags cleared by a one-cycle rd pulse.
module rx_unit #(
  parameter int unsigned OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_rx,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] d_out,
  output logic       rs,
  output logic       fe,
  output logic       oe
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam logic [3:0] HALF = 4'(OVS / 2 - 1);
  localparam logic [3:0] LAST = 4'(OVS - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shift;
  logic       r_sync1;
  logic       r_sync2;
  logic       w_cnt_clr;
  logic       w_shift_en;
  logic       w_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Every decision is qualified by en_rx here, so the sequential block only
  // needs to gate the counter/state update on the tick itself.
  always_comb begin
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_done     = 1'b0;
    if (en_rx) begin
      unique case (r_state)
        IDLE: begin
          if (!r_sync2) begin
            w_next    = START;
            w_cnt_clr = 1'b1;
          end
        end
        START: begin
          if (r_cnt == HALF) begin
            w_cnt_clr = 1'b1;
            w_next    = r_sync2 ? IDLE : DATA;
          end
        end
        DATA: begin
          if (r_cnt == LAST) begin
            w_cnt_clr  = 1'b1;
            w_shift_en = 1'b1;
            if (r_bitcnt == 3'd7) w_next = STOP;
          end
        end
        STOP: begin
          if (r_cnt == LAST) begin
            w_cnt_clr = 1'b1;
            w_done    = 1'b1;
            w_next    = r_sync2 ? IDLE : BREAK;
          end
        end
        BREAK: begin
          if (r_sync2) begin
            w_next    = IDLE;
            w_cnt_clr = 1'b1;
          end
        end
        default: begin
          w_next    = IDLE;
          w_cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else if (en_rx) begin
      r_state <= w_next;
      r_cnt   <= w_cnt_clr ? 4'd0 : r_cnt + 4'd1;
      if (r_state == START) begin
        r_bitcnt <= '0;
      end else if (w_shift_en) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_shift_en) r_shift <= {r_sync2, r_shift[7:1]};
    end
  end

  // A completing frame takes priority over a coincident rd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out <= '0;
      rs    <= 1'b0;
      fe    <= 1'b0;
      oe    <= 1'b0;
    end else if (w_done) begin
      d_out <= r_shift;
      rs    <= 1'b1;
      fe    <= ~r_sync2;
      oe    <= rs & ~rd;
    end else if (rd) begin
      rs <= 1'b0;
      fe <= 1'b0;
      oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_unit.sv
// Directed bench for rx_unit (OVS=16, en_rx every clk): frame reception,
// glitch rejection, framing error/break, overrun, rd priority and async reset.
module tb_rx_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_rx;
  logic       rxd;
  logic       rd;
  logic [7:0] d_out;
  logic       rs;
  logic       fe;
  logic       oe;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rx_unit #(.OVS(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .en_rx (en_rx),
    .rxd   (rxd),
    .rd    (rd),
    .d_out (d_out),
    .rs    (rs),
    .fe    (fe),
    .oe    (oe)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Line falls just after an edge; with the synchronizer the stop-bit sample
  // lands on the 155th edge (2 sync + 1 detect + 8 start + 8*16 data + 16 stop).
  task automatic send_frame(input logic [7:0] b, input logic stopv, input int stop_len,
                            input logic rd_done, input string tag,
                            input logic exp_rs_pre, input logic exp_fe, input logic exp_oe);
    rxd = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(16);
    end
    rxd = stopv;
    tick(10);
    chk1({tag, ".rs_pre"}, rs, exp_rs_pre);
    rd = rd_done;
    tick(1);
    rd = 1'b0;
    chk8({tag, ".d_out"}, d_out, b);
    chk1({tag, ".rs"}, rs, 1'b1);
    chk1({tag, ".fe"}, fe, exp_fe);
    chk1({tag, ".oe"}, oe, exp_oe);
    tick(stop_len - 11);
    rxd = 1'b1;
  endtask

  task automatic pulse_rd(input string tag, input logic [7:0] exp_d);
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    chk1({tag, ".rs"}, rs, 1'b0);
    chk1({tag, ".fe"}, fe, 1'b0);
    chk1({tag, ".oe"}, oe, 1'b0);
    chk8({tag, ".d_out"}, d_out, exp_d);
  endtask

  initial begin
    rst   = 1'b1;
    en_rx = 1'b1;
    rxd   = 1'b1;
    rd    = 1'b0;
    tick(3);
    chk8("reset.d_out", d_out, 8'h00);
    chk1("reset.rs", rs, 1'b0);
    chk1("reset.fe", fe, 1'b0);
    chk1("reset.oe", oe, 1'b0);
    rst = 1'b0;
    tick(5);

    send_frame(8'hA5, 1'b1, 16, 1'b0, "a5", 1'b0, 1'b0, 1'b0);
    tick(20);
    pulse_rd("rd_a5", 8'hA5);

    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(30);
    chk1("glitch.rs", rs, 1'b0);
    chk1("glitch.fe", fe, 1'b0);
    chk1("glitch.oe", oe, 1'b0);
    chk8("glitch.d_out", d_out, 8'hA5);

    // Stop bit held low for 40 ticks leaves the receiver in BREAK.
    send_frame(8'h3C, 1'b0, 40, 1'b0, "brk3c", 1'b0, 1'b1, 1'b0);
    tick(20);
    send_frame(8'h01, 1'b1, 16, 1'b0, "after_brk", 1'b1, 1'b0, 1'b1);
    tick(4);

    en_rx = 1'b0;
    pulse_rd("rd_frozen", 8'h01);
    en_rx = 1'b1;
    tick(4);

    send_frame(8'h55, 1'b1, 16, 1'b0, "f55", 1'b0, 1'b0, 1'b0);
    tick(4);
    send_frame(8'hAA, 1'b1, 16, 1'b0, "ovr_aa", 1'b1, 1'b0, 1'b1);
    tick(4);
    pulse_rd("rd_aa", 8'hAA);
    tick(4);

    send_frame(8'h33, 1'b1, 16, 1'b0, "f33", 1'b0, 1'b0, 1'b0);
    tick(4);
    send_frame(8'h66, 1'b1, 16, 1'b0, "ovr66", 1'b1, 1'b0, 1'b1);
    tick(4);
    send_frame(8'h0F, 1'b1, 16, 1'b1, "rdwin0f", 1'b1, 1'b0, 1'b0);
    tick(4);

    rxd = 1'b0;
    tick(16);
    rxd = 1'b1;
    tick(16 * 4 + 5);
    rst = 1'b1;
    #1;
    chk8("rst_mid.d_out", d_out, 8'h00);
    chk1("rst_mid.rs", rs, 1'b0);
    chk1("rst_mid.fe", fe, 1'b0);
    chk1("rst_mid.oe", oe, 1'b0);
    tick(3);
    rst = 1'b0;
    tick(200);
    chk1("partial.rs", rs, 1'b0);
    chk8("partial.d_out", d_out, 8'h00);
    send_frame(8'h12, 1'b1, 16, 1'b0, "f12", 1'b0, 1'b0, 1'b0);
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
